// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default timing and counter sizing shared by the UART transmitter and receiver
package uart_pkg;
   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] START = 2'b01;
   localparam logic [1:0] DATA  = 2'b10;
   localparam logic [1:0] STOP  = 2'b11;
   localparam int DEF_CLOCKS_PER_PULSE = 4;
   localparam int DEF_BITS_PER_WORD = 8;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready parallel word handshake into the UART transmitter
interface uart_tx_if #(
   parameter int W_IN = 24
);
   logic            s_valid;
   logic            s_ready;
   logic [W_IN-1:0] s_data;
   modport master (output s_valid, output s_data, input s_ready);
   modport slave (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter with clear, tc high on the last cycle of each serial bit
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tc
);
   localparam int CW = $clog2(CLOCKS_PER_PULSE);
   logic [CW-1:0] cnt;
   assign tc = cnt == CW'(CLOCKS_PER_PULSE - 1);
   always_ff @(posedge clk)
      cnt <= (rst || clr || tc) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises a W_IN-bit word as NUM_WORDS back-to-back 8N1 characters, character 0 first, LSB first
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
   parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
   parameter int W_IN = 24
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave s,
   output logic     tx,
   output logic     busy
);
   localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
   localparam int BW = $clog2(BITS_PER_WORD);
   localparam int WW = cnt_width(NUM_WORDS);
   logic [1:0]      state;
   logic [W_IN-1:0] shreg;
   logic [BW-1:0]   bit_cnt;
   logic [WW-1:0]   word_cnt;
   logic            tc;
   logic            bit_last;
   logic            word_last;
   uart_baud_cnt #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)) u_baud (
      .clk(clk),
      .rst(rst),
      .clr(state == IDLE),
      .tc(tc)
   );
   assign s.s_ready = state == IDLE;
   assign busy = state != IDLE;
   assign bit_last = bit_cnt == BW'(BITS_PER_WORD - 1);
   assign word_last = word_cnt == WW'(NUM_WORDS - 1);
   // tx is loaded with the level of the state being entered so the line is registered without extra latency
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         bit_cnt <= '0;
         word_cnt <= '0;
         tx <= 1'b1;
      end else if (state == IDLE) begin
         if (s.s_valid) begin
            state <= START;
            shreg <= s.s_data;
            tx <= 1'b0;
         end
      end else if (tc) begin
         if (state == START) begin
            state <= DATA;
            tx <= shreg[0];
         end else if (state == DATA) begin
            shreg <= shreg >> 1;
            bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            state <= bit_last ? STOP : DATA;
            tx <= bit_last ? 1'b1 : shreg[1];
         end else begin
            word_cnt <= word_last ? '0 : word_cnt + 1'b1;
            state <= word_last ? IDLE : START;
            tx <= word_last;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of framing, handshake, reset abort and parameter variants of uart_tx
module tb_uart_tx;
   logic clk;
   logic rst;
   logic tx0, tx1, tx2, busy0, busy1, busy2;
   int   n_vec = 0;
   int   n_err = 0;
   logic [23:0] w;
   int   nb;
   uart_tx_if #(.W_IN(24)) s0 ();
   uart_tx_if #(.W_IN(8)) s1 ();
   uart_tx_if #(.W_IN(8)) s2 ();
   uart_tx #(.CLOCKS_PER_PULSE(4), .BITS_PER_WORD(8), .W_IN(24)) dut0 (
      .clk(clk), .rst(rst), .s(s0), .tx(tx0), .busy(busy0));
   uart_tx #(.CLOCKS_PER_PULSE(2), .BITS_PER_WORD(8), .W_IN(8)) dut1 (
      .clk(clk), .rst(rst), .s(s1), .tx(tx1), .busy(busy1));
   uart_tx #(.CLOCKS_PER_PULSE(434), .BITS_PER_WORD(8), .W_IN(8)) dut2 (
      .clk(clk), .rst(rst), .s(s2), .tx(tx2), .busy(busy2));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [2:0] obs(input int sel);
      return (sel == 0) ? {busy0, tx0, s0.s_ready} :
             (sel == 1) ? {busy1, tx1, s1.s_ready} : {busy2, tx2, s2.s_ready};
   endfunction
   task automatic drive(input int sel, input logic v, input logic [23:0] d);
      if (sel == 0) begin s0.s_valid = v; s0.s_data = d; end
      else if (sel == 1) begin s1.s_valid = v; s1.s_data = d[7:0]; end
      else begin s2.s_valid = v; s2.s_data = d[7:0]; end
   endtask
   task automatic setv(input int sel, input logic v);
      if (sel == 0) s0.s_valid = v;
      else if (sel == 1) s1.s_valid = v;
      else s2.s_valid = v;
   endtask
   // called on the first negedge after the accepting edge; walks every line cycle of the frame
   task automatic expect_frame(input int sel, input int cpp, input int nw, input logic [23:0] d,
                               input bit keep, input int pulse, input string tag);
      int bad, busy_n, cyc;
      logic [7:0] ch;
      logic e;
      logic [2:0] o;
      bad = 0;
      busy_n = 0;
      cyc = 0;
      if (!keep) setv(sel, 1'b0);
      for (int k = 0; k < nw; k++) begin
         ch = '0;
         for (int b = 0; b < 10; b++)
            for (int c = 0; c < cpp; c++) begin
               o = obs(sel);
               e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[k*8+b-1];
               if (o[1] !== e) bad++;
               if (o[2] === 1'b1) busy_n++;
               if (c == cpp / 2 && b > 0 && b < 9) ch[b-1] = o[1];
               if (cyc == pulse) begin s0.s_valid = 1'b1; s0.s_data = 24'h123456; end
               else if (pulse >= 0 && cyc == pulse + 1) s0.s_valid = 1'b0;
               cyc++;
               @(negedge clk);
            end
         check($sformatf("%s_char%0d", tag, k), 32'(ch), 32'(d[k*8+:8]));
      end
      check({tag, "_bad_cycles"}, bad, 0);
      check({tag, "_busy_len"}, busy_n, nw * 10 * cpp);
      check({tag, "_idle_after"}, 32'(obs(sel)), 32'b011);
   endtask
   initial begin
      rst = 1'b1;
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      drive(2, 1'b0, '0);
      repeat (3) @(negedge clk);
      check("reset_dut0", 32'({busy0, tx0}), 32'b01);
      check("reset_dut1", 32'({busy1, tx1}), 32'b01);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(obs(0)), 32'b011);
      drive(0, 1'b1, 24'hA5C30F);
      @(negedge clk);
      expect_frame(0, 4, 3, 24'hA5C30F, 1'b0, -1, "single");
      drive(0, 1'b1, 24'h000000);
      @(negedge clk);
      s0.s_data = 24'hFFFFFF;
      expect_frame(0, 4, 3, 24'h000000, 1'b1, -1, "b2b_first");
      @(negedge clk);
      expect_frame(0, 4, 3, 24'hFFFFFF, 1'b0, -1, "b2b_second");
      drive(0, 1'b1, 24'hA5C30F);
      @(negedge clk);
      expect_frame(0, 4, 3, 24'hA5C30F, 1'b0, 50, "busy_ignore");
      nb = 0;
      repeat (40) begin
         if (busy0 !== 1'b0 || tx0 !== 1'b1) nb++;
         @(negedge clk);
      end
      check("no_extra_frame", nb, 0);
      drive(0, 1'b1, 24'h3C96E1);
      @(negedge clk);
      s0.s_valid = 1'b0;
      repeat (54) @(negedge clk);
      rst = 1'b1;
      drive(0, 1'b1, 24'h123456);
      @(negedge clk);
      check("midframe_reset", 32'({busy0, tx0}), 32'b01);
      rst = 1'b0;
      s0.s_valid = 1'b0;
      @(negedge clk);
      check("valid_ignored_in_reset", 32'(obs(0)), 32'b011);
      drive(0, 1'b1, 24'h817E42);
      @(negedge clk);
      expect_frame(0, 4, 3, 24'h817E42, 1'b0, -1, "after_reset");
      for (int i = 0; i < 4; i++) begin
         w = 24'($urandom);
         drive(0, 1'b1, w);
         @(negedge clk);
         expect_frame(0, 4, 3, w, 1'b0, -1, $sformatf("rand%0d", i));
      end
      drive(1, 1'b1, 24'h00003C);
      @(negedge clk);
      expect_frame(1, 2, 1, 24'h00003C, 1'b0, -1, "cpp2_w8");
      drive(2, 1'b1, 24'h0000A6);
      @(negedge clk);
      expect_frame(2, 434, 1, 24'h0000A6, 1'b0, -1, "cpp434_w8");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
